// File: rtl/analog_probe_sched_if.sv
// Requester/consumer bundle for analog_probe_sched: per-requester request
// lines with one-hot accept, plus the single valid/ready response channel.
interface analog_probe_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int NODE_W  = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*NODE_W-1:0] req_node;
  logic [NUM_REQ-1:0]        req_kind;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic                      resp_kind;
  real                       resp_value;
  logic                      resp_err;

  modport master (
    output req_valid, req_node, req_kind, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_kind, resp_value, resp_err
  );

  modport slave (
    input  req_valid, req_node, req_kind, resp_ready,
    output req_ready, resp_valid, resp_id, resp_kind, resp_value, resp_err
  );
endinterface

// File: rtl/analog_probe_sched.sv
// Round-robin sequencer sharing one analog probe among NUM_REQ requesters.
// Optional range check on captured values: ANALOG_PROBE_SCHED_RANGE_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for a request; grants round-robin from last_grant+1
// SETUP   | probe_node driven; selected toggle flips at end of cycle
// WAIT    | settle down-counter running
// CAPTURE | probe result sampled, range error computed
// DONE    | response presented until resp_ready
module analog_probe_sched #(
  parameter int  NUM_REQ       = 4,
  parameter int  NODE_W        = 4,
  parameter int  SETTLE_CYCLES = 2,
  parameter real V_LO          = -1.0,
  parameter real V_HI          = 5.0,
  parameter real I_LO          = -0.01,
  parameter real I_HI          = 0.01
) (
  input  logic                 clk,
  input  logic                 reset_n,
  analog_probe_sched_if.slave  bus,
  output logic                 busy,
  output logic [NODE_W-1:0]    probe_node,
  output logic                 probe_voltage_toggle,
  output logic                 probe_current_toggle,
  input  real                  probe_voltage,
  input  real                  probe_current
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_q, id_q, gnt_idx;
  logic [ID_W:0]       cand;
  logic                gnt_hit;
  logic [NODE_W-1:0]   node_q;
  logic                kind_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                tog_v_q, tog_i_q;
  logic [NUM_REQ-1:0]  req_ready_d;
  real                 value_q;
  real                 sample_r;
  logic                err_q;
  logic                range_err;

  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ))
        cand = cand - (ID_W+1)'(NUM_REQ);
      if (!gnt_hit && bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  assign sample_r = kind_q ? probe_current : probe_voltage;

`ifdef ANALOG_PROBE_SCHED_RANGE_CHECK_EN
  assign range_err = kind_q ? ((sample_r < I_LO) || (sample_r > I_HI))
                            : ((sample_r < V_LO) || (sample_r > V_HI));
`else
  logic unused_range_cfg;
  assign range_err        = 1'b0;
  assign unused_range_cfg = (V_LO > V_HI) || (I_LO > I_HI);
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    case (state_q)
      S_IDLE: begin
        // grants are held off while reset is asserted so no accept is lost
        if (gnt_hit && reset_n) begin
          state_d              = S_SETUP;
          req_ready_d[gnt_idx] = 1'b1;
        end
      end
      S_SETUP:   state_d = (SETTLE_CYCLES <= 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if ({1'b0, cnt_q} <= (CNT_W+1)'(2)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    if (bus.resp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      node_q  <= '0;
      kind_q  <= 1'b0;
      cnt_q   <= '0;
      tog_v_q <= 1'b0;
      tog_i_q <= 1'b0;
      value_q <= 0.0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (gnt_hit) begin
            id_q   <= gnt_idx;
            node_q <= bus.req_node[gnt_idx*NODE_W +: NODE_W];
            kind_q <= bus.req_kind[gnt_idx];
          end
        end
        S_SETUP: begin
          if (kind_q) tog_i_q <= ~tog_i_q;
          else        tog_v_q <= ~tog_v_q;
          cnt_q <= CNT_W'(SETTLE_CYCLES);
        end
        S_WAIT: cnt_q <= cnt_q - 1'b1;
        S_CAPTURE: begin
          value_q <= sample_r;
          err_q   <= range_err;
`ifdef ANALOG_PROBE_SCHED_RANGE_CHECK_EN
          if (range_err)
            $display("analog_probe_sched: out of range id=%0d node=%0d value=%f",
                     id_q, node_q, sample_r);
`endif
        end
        S_DONE: if (bus.resp_ready) last_q <= id_q;
        default: ;
      endcase
    end
  end

  assign bus.req_ready        = req_ready_d;
  assign bus.resp_valid       = (state_q == S_DONE);
  assign bus.resp_id          = id_q;
  assign bus.resp_kind        = kind_q;
  assign bus.resp_value       = value_q;
  assign bus.resp_err         = err_q;
  assign busy                 = (state_q != S_IDLE);
  assign probe_node           = node_q;
  assign probe_voltage_toggle = tog_v_q;
  assign probe_current_toggle = tog_i_q;
endmodule

// File: tb/tb_analog_probe_sched.sv
// Bench for analog_probe_sched: directed vector table and corner sequences,
// then random traffic checked against a cycle-level transaction model.
module tb_analog_probe_sched;
  localparam int N  = 4;
  localparam int NW = 4;
  localparam int S  = 2;
`ifdef ANALOG_PROBE_SCHED_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          busy;
  logic [NW-1:0] probe_node;
  logic          tog_v, tog_i;
  real           probe_voltage = 0.0;
  real           probe_current = 0.0;

  analog_probe_sched_if #(.NUM_REQ(N), .NODE_W(NW)) bus ();

  analog_probe_sched #(.NUM_REQ(N), .NODE_W(NW), .SETTLE_CYCLES(S)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .bus                  (bus.slave),
    .busy                 (busy),
    .probe_node           (probe_node),
    .probe_voltage_toggle (tog_v),
    .probe_current_toggle (tog_i),
    .probe_voltage        (probe_voltage),
    .probe_current        (probe_current)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  // transaction model state
  int   last_m = N - 1;
  bit   in_fl = 1'b0;
  int   g_id, g_node, g_cyc;
  bit   g_kind, g_err, g_tv, g_ti;
  real  g_val;
  int   last_hs_cyc = 0;
  bit   saw_done = 1'b0;
  bit   rerequest_all = 1'b0;
  logic [N-1:0] rdy_seen = '0;
  logic prev_tv = 1'b0, prev_ti = 1'b0;
  real  vtab[16], itab[16];
  int   gnt_q[$], gnt_cyc_q[$], resp_id_q[$];

  typedef struct { int id; int node; bit kind; real val; bit err_rc; } vec_t;
  vec_t tv[8];

  task automatic chk_i(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_r(string nm, real act, real exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %f expected %f (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit err_m(bit kind, real v);
    if (!RC_EN) return 1'b0;
    return kind ? (v < -0.01 || v > 0.01) : (v < -1.0 || v > 5.0);
  endfunction

  // Compare DUT against the transaction-level expectation for this cycle.
  task automatic observe();
    int n, win;
    n   = cyc - g_cyc;
    win = -1;
    saw_done = 1'b0;
    chk_i("busy", longint'(busy), longint'(in_fl));
    chk_i("resp_valid", longint'(bus.resp_valid), longint'(in_fl && n >= S + 2));
    if (!in_fl && reset_n)
      for (int k = 1; k <= N; k++) begin
        int c = (last_m + k) % N;
        if (win < 0 && bus.req_valid[c]) win = c;
      end
    chk_i("req_ready", longint'(bus.req_ready), (win >= 0) ? (longint'(1) << win) : 0);
    if (in_fl) begin
      chk_i("probe_node", longint'(probe_node), g_node);
      chk_i("tog_v", longint'(tog_v), longint'(g_tv ^ (n >= 2 && !g_kind)));
      chk_i("tog_i", longint'(tog_i), longint'(g_ti ^ (n >= 2 && g_kind)));
    end
    if (in_fl && bus.resp_valid) begin
      saw_done = 1'b1;
      chk_i("resp_id", longint'(bus.resp_id), g_id);
      chk_i("resp_kind", longint'(bus.resp_kind), longint'(g_kind));
      chk_r("resp_value", bus.resp_value, g_val);
      chk_i("resp_err", longint'(bus.resp_err), longint'(g_err));
      if (bus.resp_ready) begin
        in_fl = 1'b0;
        last_m = g_id;
        last_hs_cyc = cyc;
        resp_id_q.push_back(g_id);
      end
    end
    rdy_seen = bus.req_ready;
    if (win >= 0) begin
      in_fl  = 1'b1;
      g_id   = win;
      g_node = int'(bus.req_node[win*NW +: NW]);
      g_kind = bus.req_kind[win];
      g_val  = g_kind ? itab[g_node] : vtab[g_node];
      g_err  = err_m(g_kind, g_val);
      g_cyc  = cyc;
      g_tv   = tog_v;
      g_ti   = tog_i;
      gnt_q.push_back(win);
      gnt_cyc_q.push_back(cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    if (!reset_n) begin
      in_fl  = 1'b0;
      last_m = N - 1;
    end
    #1;
    cyc++;
    // probe stand-in: fresh value on a toggle edge, junk once captured
    if (saw_done) begin
      probe_voltage = -77.0;
      probe_current = 77.0;
    end
    if (tog_v !== prev_tv) probe_voltage = vtab[probe_node];
    if (tog_i !== prev_ti) probe_current = itab[probe_node];
    prev_tv = tog_v;
    prev_ti = tog_i;
    for (int i = 0; i < N; i++)
      if (rdy_seen[i]) bus.req_valid[i] = 1'b0;
    if (rerequest_all) bus.req_valid = '1;
  endtask

  task automatic request(int id, int node, bit kind);
    bus.req_node[id*NW +: NW] = NW'(node);
    bus.req_kind[id]          = kind;
    bus.req_valid[id]         = 1'b1;
  endtask

  task automatic drain();
    bus.req_valid   = '0;
    bus.resp_ready  = 1'b1;
    for (int k = 0; k < 40 && in_fl; k++) step();
    chk_i("drain_idle", longint'(in_fl), 0);
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk_i({tag, "_busy"}, longint'(busy), 0);
    chk_i({tag, "_resp_valid"}, longint'(bus.resp_valid), 0);
    chk_i({tag, "_req_ready"}, longint'(bus.req_ready), 0);
    chk_i({tag, "_resp_id"}, longint'(bus.resp_id), 0);
    chk_i({tag, "_resp_err"}, longint'(bus.resp_err), 0);
    chk_r({tag, "_resp_value"}, bus.resp_value, 0.0);
    chk_i({tag, "_probe_node"}, longint'(probe_node), 0);
    chk_i({tag, "_toggles"}, longint'({tog_v, tog_i}), 0);
  endtask

  initial begin
    int start, gcount, marker, cnt3;
    int exp_order[5];
    bus.req_valid  = '0;
    bus.req_node   = '0;
    bus.req_kind   = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vtab[i] = 0.5 * i;
      itab[i] = 0.0005 * i;
    end

    tv[0] = '{2, 5,  1'b0, 1.25,  1'b0};
    tv[1] = '{1, 3,  1'b1, 0.004, 1'b0};
    tv[2] = '{0, 7,  1'b0, 5.0,   1'b0};
    tv[3] = '{3, 9,  1'b0, 5.01,  1'b1};
    tv[4] = '{2, 1,  1'b1, -0.02, 1'b1};
    tv[5] = '{1, 15, 1'b0, -1.0,  1'b0};
    tv[6] = '{0, 4,  1'b1, 0.01,  1'b0};
    tv[7] = '{3, 2,  1'b0, -1.5,  1'b1};

    // reset state
    @(posedge clk);
    #1;
    step();
    step();
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // single-transaction vector table
    foreach (tv[j]) begin
      if (tv[j].kind) itab[tv[j].node] = tv[j].val;
      else            vtab[tv[j].node] = tv[j].val;
      request(tv[j].id, tv[j].node, tv[j].kind);
      start = resp_id_q.size();
      for (int k = 0; k < 40 && resp_id_q.size() == start; k++) step();
      chk_i("vec_done", resp_id_q.size(), start + 1);
      chk_i("vec_id", longint'(bus.resp_id), tv[j].id);
      chk_i("vec_kind", longint'(bus.resp_kind), longint'(tv[j].kind));
      chk_r("vec_value", bus.resp_value, tv[j].val);
      chk_i("vec_err", longint'(bus.resp_err), longint'(RC_EN & tv[j].err_rc));
    end
    drain();

    // all requesters contending: 0,1,2,3,0 spaced S+3 apart
    do_reset();
    for (int i = 0; i < N; i++) request(i, i + 8, 1'b0);
    gnt_q.delete();
    gnt_cyc_q.delete();
    rerequest_all = 1'b1;
    for (int k = 0; k < 60 && gnt_q.size() < 5; k++) step();
    rerequest_all = 1'b0;
    chk_i("rr_count", gnt_q.size() >= 5, 1);
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5 && i < gnt_q.size(); i++) begin
      chk_i("rr_order", gnt_q[i], exp_order[i]);
      if (i > 0) chk_i("rr_spacing", gnt_cyc_q[i] - gnt_cyc_q[i-1], S + 3);
    end
    drain();

    // response back-pressure: DONE held, requester 0 waits
    itab[3] = 0.003;
    bus.resp_ready = 1'b0;
    request(1, 3, 1'b1);
    for (int k = 0; k < 20 && !(in_fl && bus.resp_valid); k++) step();
    chk_i("stall_done", longint'(bus.resp_valid), 1);
    request(0, 6, 1'b0);
    gcount = gnt_q.size();
    for (int k = 0; k < 10; k++) step();
    chk_i("stall_no_grant", gnt_q.size(), gcount);
    chk_i("stall_id", longint'(bus.resp_id), 1);
    chk_r("stall_value", bus.resp_value, 0.003);
    bus.resp_ready = 1'b1;
    step();
    step();
    chk_i("stall_next_grant", gnt_q.size(), gcount + 1);
    if (gnt_q.size() == gcount + 1) begin
      chk_i("stall_next_id", gnt_q[$], 0);
      chk_i("stall_next_cyc", gnt_cyc_q[$] - last_hs_cyc, 1);
    end
    drain();

    // reset asserted in WAIT
    vtab[6] = 2.5;
    request(0, 6, 1'b0);
    for (int k = 0; k < 20 && !(in_fl && cyc - g_cyc == 2); k++) step();
    chk_i("wait_reached", longint'(busy), 1);
    reset_n = 1'b0;
    step();
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    start = resp_id_q.size();
    request(0, 6, 1'b0);
    for (int k = 0; k < 40 && resp_id_q.size() == start; k++) step();
    chk_i("after_reset_done", resp_id_q.size(), start + 1);
    chk_r("after_reset_value", bus.resp_value, 2.5);
    drain();

    // requester 3 withdraws while another transaction is busy
    marker = gnt_q.size();
    start  = resp_id_q.size();
    request(1, 2, 1'b0);
    for (int k = 0; k < 10 && !in_fl; k++) step();
    request(3, 11, 1'b1);
    step();
    step();
    bus.req_valid[3] = 1'b0;
    drain();
    for (int k = 0; k < 5; k++) step();
    cnt3 = 0;
    for (int i = marker; i < gnt_q.size(); i++) if (gnt_q[i] == 3) cnt3++;
    for (int i = start; i < resp_id_q.size(); i++) if (resp_id_q[i] == 3) cnt3++;
    chk_i("withdraw_id3", cnt3, 0);

    // random traffic against the model
    for (int i = 0; i < 16; i++) begin
      vtab[i] = real'(int'($urandom_range(0, 1400)) - 200) / 200.0;
      itab[i] = real'(int'($urandom_range(0, 600)) - 300) / 10000.0;
    end
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && ($urandom % 4) == 0)
          request(i, int'($urandom_range(0, 15)), 1'($urandom % 2));
        else if (bus.req_valid[i] && ($urandom % 16) == 0)
          bus.req_valid[i] = 1'b0;
      end
      bus.resp_ready = ($urandom % 3) != 0;
      if (!in_fl) begin
        int e = int'($urandom_range(0, 15));
        vtab[e] = real'(int'($urandom_range(0, 1400)) - 200) / 200.0;
        itab[e] = real'(int'($urandom_range(0, 600)) - 300) / 10000.0;
      end
      reset_n = ($urandom % 500) != 0;
    end
    reset_n = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
